// File: rtl/fifo_drain_scheduler_if.sv
// Bus bundle between the drain scheduler, the addressed FIFOs and the UART transmitter.
// The master side is the scheduler. The slave side is the FIFO/transmitter environment.
interface fifo_drain_scheduler_if #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned ADRESS_WIDTH = 4,
  parameter int unsigned DATA_WIDTH   = 8
);

  localparam int unsigned GrantWidth = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  // Arbitration inputs
  logic [NUM_CHANNELS-1:0] channel_enable;
  logic [NUM_CHANNELS-1:0] fifo_empty;

  // Shared FIFO pop bus
  logic [DATA_WIDTH-1:0]   fifo_data;
  logic [ADRESS_WIDTH-1:0] pop_adress;
  logic                    pop_enable;

  // Transmit handshake
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_valid;
  logic                    tx_ready;

  // Status
  logic                    busy;
  logic [GrantWidth-1:0]   grant;

  modport master (
    input  channel_enable,
    input  fifo_empty,
    input  fifo_data,
    input  tx_ready,
    output pop_adress,
    output pop_enable,
    output tx_data,
    output tx_valid,
    output busy,
    output grant
  );

  modport slave (
    output channel_enable,
    output fifo_empty,
    output fifo_data,
    output tx_ready,
    input  pop_adress,
    input  pop_enable,
    input  tx_data,
    input  tx_valid,
    input  busy,
    input  grant
  );

endinterface

// File: rtl/fifo_drain_scheduler.sv
// Round-robin drain scheduler: pops bytes from NUM_CHANNELS addressed FIFOs over a shared bus
// and hands them one at a time to a single transmitter on a valid/ready handshake.
// Up to BURST_LENGTH bytes are drained from a granted channel before the pointer rotates.
module fifo_drain_scheduler #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned ADRESS_WIDTH = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BASE_ADRESS  = 0,
  parameter int unsigned BURST_LENGTH = 1
) (
  input logic                    clock,
  input logic                    reset,
  fifo_drain_scheduler_if.master bus
);

  localparam int unsigned GrantWidth = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  // Must hold the value BURST_LENGTH itself, reached on the last byte of a full burst.
  localparam int unsigned BurstWidth = $clog2(BURST_LENGTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StPop,
    StCapture,
    StSend
  } state_e;

  state_e                  state;
  logic [GrantWidth-1:0]   rr_pointer;
  logic [GrantWidth-1:0]   grant_q;
  logic [BurstWidth-1:0]   burst_count;
  logic [ADRESS_WIDTH-1:0] pop_adress_q;
  logic                    pop_enable_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic                    tx_valid_q;
  logic                    busy_q;

  logic [NUM_CHANNELS-1:0] eligible;
  logic                    pick_valid;
  logic [GrantWidth-1:0]   pick;
  logic [ADRESS_WIDTH-1:0] pick_adress;
  logic [GrantWidth-1:0]   grant_wrap;
  logic                    burst_more;

  assign eligible = bus.channel_enable & ~bus.fifo_empty;

  // Rotating priority search: first eligible channel at or above rr_pointer, with wrap.
  always_comb begin
    int unsigned idx;
    pick_valid = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      idx = (32'(rr_pointer) + k) % NUM_CHANNELS;
      if (!pick_valid && eligible[idx[GrantWidth-1:0]]) begin
        pick_valid = 1'b1;
        pick       = idx[GrantWidth-1:0];
      end
    end
  end

  // Address of the picked channel, truncated to the bus width.
  assign pick_adress = ADRESS_WIDTH'(BASE_ADRESS + 32'(pick));

  // Next round-robin start point once the current grant ends.
  assign grant_wrap = (32'(grant_q) == NUM_CHANNELS - 1) ? '0 : grant_q + 1'b1;

  // Stay on the granted channel only while the burst has room and it still has data and is
  // enabled; masking mid-byte never aborts the byte already in flight.
  assign burst_more = (32'(burst_count) + 32'd1 < BURST_LENGTH) &&
                      bus.channel_enable[grant_q] && !bus.fifo_empty[grant_q];

  // Scheduler FSM with registered bus and handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= StIdle;
      rr_pointer   <= '0;
      grant_q      <= '0;
      burst_count  <= '0;
      pop_adress_q <= '0;
      pop_enable_q <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (pick_valid) begin
            grant_q      <= pick;
            pop_adress_q <= pick_adress;
            burst_count  <= '0;
            pop_enable_q <= 1'b1;
            busy_q       <= 1'b1;
            state        <= StPop;
          end
        end
        StPop: begin
          // The addressed FIFO registers its output on this edge.
          pop_enable_q <= 1'b0;
          state        <= StCapture;
        end
        StCapture: begin
          tx_data_q  <= bus.fifo_data;
          tx_valid_q <= 1'b1;
          state      <= StSend;
        end
        StSend: begin
          if (bus.tx_ready) begin
            tx_valid_q  <= 1'b0;
            burst_count <= burst_count + 1'b1;
            if (burst_more) begin
              pop_enable_q <= 1'b1;
              state        <= StPop;
            end else begin
              rr_pointer <= grant_wrap;
              busy_q     <= 1'b0;
              state      <= StIdle;
            end
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign bus.pop_adress = pop_adress_q;
  assign bus.pop_enable = pop_enable_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.busy       = busy_q;
  assign bus.grant      = grant_q;

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// Directed bench for fifo_drain_scheduler. Instance 0 uses BURST_LENGTH=1 and instance 1 uses
// BURST_LENGTH=4. Each instance has four queue-backed FIFO models and a transmit log.
module tb_fifo_drain_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  // Per-instance stimulus and observed signals
  logic [3:0] en      [2];
  logic       txr     [2];
  logic [3:0] empty_w [2];
  logic [7:0] fdata   [2];
  logic [3:0] padr    [2];
  logic       pen     [2];
  logic [7:0] txd     [2];
  logic       txv     [2];
  logic       busy_w  [2];
  logic [1:0] gnt     [2];

  // FIFO models: pushed by the stimulus, popped by the DUT
  logic [7:0] mem    [2][4][16];
  logic [3:0] wr_ptr [2][4] = '{default: '0};
  logic [3:0] rd_ptr [2][4] = '{default: '0};

  logic [7:0] txlog [2][64];
  int         txn   [2] = '{0, 0};
  int         pop2  [2] = '{0, 0};
  int         inv_err = 0;

  int n_checks = 0;
  int n_errors = 0;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    fifo_drain_scheduler_if #(
      .NUM_CHANNELS(4),
      .ADRESS_WIDTH(4),
      .DATA_WIDTH  (8)
    ) bus ();

    assign bus.channel_enable = en[d];
    assign bus.fifo_empty     = empty_w[d];
    assign bus.fifo_data      = fdata[d];
    assign bus.tx_ready       = txr[d];
    assign padr[d]            = bus.pop_adress;
    assign pen[d]             = bus.pop_enable;
    assign txd[d]             = bus.tx_data;
    assign txv[d]             = bus.tx_valid;
    assign busy_w[d]          = bus.busy;
    assign gnt[d]             = bus.grant;

    fifo_drain_scheduler #(
      .NUM_CHANNELS(4),
      .ADRESS_WIDTH(4),
      .DATA_WIDTH  (8),
      .BASE_ADRESS (0),
      .BURST_LENGTH((d == 0) ? 1 : 4)
    ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
    );
  end

  // FIFO empty flags
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        empty_w[d][c] = (rd_ptr[d][c] == wr_ptr[d][c]);
      end
    end
  end

  // FIFO pop model (registered data_out, zero when idle) and transmit monitor
  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      fdata[d] <= '0;
      if (pen[d] === 1'b1) begin
        if (empty_w[d][padr[d][1:0]]) begin
          inv_err <= inv_err + 1;
        end else begin
          fdata[d] <= mem[d][padr[d][1:0]][rd_ptr[d][padr[d][1:0]]];
          rd_ptr[d][padr[d][1:0]] <= rd_ptr[d][padr[d][1:0]] + 4'd1;
        end
        if (padr[d] == 4'd2) pop2[d] <= pop2[d] + 1;
      end
      if (txv[d] === 1'b1 && txr[d] === 1'b1) begin
        txlog[d][txn[d] % 64] <= txd[d];
        txn[d] <= txn[d] + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int d, input int c, input logic [7:0] v);
    mem[d][c][wr_ptr[d][c]] = v;
    wr_ptr[d][c] = wr_ptr[d][c] + 4'd1;
  endtask

  // Wait (bounded) until the transmit log of instance d reaches target entries.
  task automatic wait_tx(input int d, input int target, input string tag);
    for (int i = 0; i < 300 && txn[d] < target; i++) @(negedge clock);
    check_eq(tag, txn[d], target);
  endtask

  task automatic wait_idle(input int d, input string tag);
    for (int i = 0; i < 50 && busy_w[d] !== 1'b0; i++) @(negedge clock);
    check_eq(tag, busy_w[d], 1'b0);
  endtask

  task automatic wait_valid(input int d, input string tag);
    for (int i = 0; i < 20 && txv[d] !== 1'b1; i++) @(negedge clock);
    check_eq(tag, txv[d], 1'b1);
  endtask

  initial begin
    int base;
    int p2base;
    int pen_seen;
    logic [7:0] exp3 [6];
    logic [7:0] exp4 [8];
    logic [7:0] exp6 [5];

    exp3 = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h21, 8'h31};
    exp4 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h81, 8'h82, 8'h05, 8'h06};
    exp6 = '{8'h40, 8'h51, 8'h70, 8'h41, 8'h71};

    en[0]  = 4'hF;
    en[1]  = 4'hF;
    txr[0] = 1'b1;
    txr[1] = 1'b1;

    // Reset with non-empty FIFOs and tx_ready high
    push(0, 0, 8'h77);
    push(0, 1, 8'h78);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_pop_enable", pen[0], 1'b0);
    check_eq("rst_tx_valid", txv[0], 1'b0);
    check_eq("rst_busy", busy_w[0], 1'b0);
    check_eq("rst_grant", gnt[0], 2'd0);
    check_eq("rst_pop_adress", padr[0], 4'd0);
    check_eq("rst_tx_data", txd[0], 8'h00);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_first_pop", pen[0], 1'b1);
    check_eq("rst_first_adr", padr[0], 4'd0);
    wait_tx(0, 2, "rst_drain_count");
    check_eq("rst_byte0", txlog[0][0], 8'h77);
    check_eq("rst_byte1", txlog[0][1], 8'h78);
    wait_idle(0, "rst_idle");

    // Single byte on channel 2, latency and one-cycle pop
    @(negedge clock);
    base = txn[0];
    push(0, 2, 8'hA5);
    @(negedge clock);
    check_eq("single_pop", pen[0], 1'b1);
    check_eq("single_adr", padr[0], 4'd2);
    check_eq("single_grant", gnt[0], 2'd2);
    @(negedge clock);
    check_eq("single_pop_once", pen[0], 1'b0);
    check_eq("single_valid_early", txv[0], 1'b0);
    @(negedge clock);
    check_eq("single_valid", txv[0], 1'b1);
    check_eq("single_data", txd[0], 8'hA5);
    @(negedge clock);
    check_eq("single_valid_drop", txv[0], 1'b0);
    check_eq("single_busy", busy_w[0], 1'b0);
    check_eq("single_count", txn[0], base + 1);

    // Round-robin with BURST_LENGTH=1, starting from a freshly reset pointer
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    base = txn[0];
    push(0, 0, 8'h10); push(0, 0, 8'h11);
    push(0, 1, 8'h20); push(0, 1, 8'h21);
    push(0, 3, 8'h30); push(0, 3, 8'h31);
    wait_tx(0, base + 6, "rr_count");
    for (int i = 0; i < 6; i++) check_eq($sformatf("rr_byte%0d", i), txlog[0][base + i], exp3[i]);
    wait_idle(0, "rr_idle");

    // Burst with BURST_LENGTH=4
    @(negedge clock);
    base = txn[1];
    for (int i = 1; i <= 6; i++) push(1, 0, 8'(i));
    push(1, 1, 8'h81);
    push(1, 1, 8'h82);
    wait_tx(1, base + 8, "burst_count");
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("burst_byte%0d", i), txlog[1][base + i], exp4[i]);
    end
    wait_idle(1, "burst_idle");

    // Backpressure: tx_ready low for 10 cycles
    @(negedge clock);
    txr[0] = 1'b0;
    base = txn[0];
    push(0, 0, 8'h5A);
    wait_valid(0, "bp_valid_rise");
    pen_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq($sformatf("bp_hold_valid%0d", i), txv[0], 1'b1);
      check_eq($sformatf("bp_hold_data%0d", i), txd[0], 8'h5A);
      if (pen[0] !== 1'b0) pen_seen++;
    end
    check_eq("bp_no_pop", pen_seen, 0);
    txr[0] = 1'b1;
    @(negedge clock);
    check_eq("bp_valid_drop", txv[0], 1'b0);
    check_eq("bp_count", txn[0], base + 1);
    check_eq("bp_byte", txlog[0][base], 8'h5A);
    wait_idle(0, "bp_idle");

    // Mask channel 2, then reset while a byte waits in SEND
    @(negedge clock);
    en[0]  = 4'b1011;
    txr[0] = 1'b0;
    p2base = pop2[0];
    push(0, 0, 8'h40); push(0, 0, 8'h41);
    push(0, 1, 8'h50); push(0, 1, 8'h51);
    push(0, 2, 8'h60); push(0, 2, 8'h61);
    push(0, 3, 8'h70); push(0, 3, 8'h71);
    wait_valid(0, "mask_valid_rise");
    check_eq("mask_first_data", txd[0], 8'h50);
    reset = 1'b1;
    @(negedge clock);
    check_eq("mrst_valid", txv[0], 1'b0);
    check_eq("mrst_busy", busy_w[0], 1'b0);
    check_eq("mrst_pop", pen[0], 1'b0);
    reset  = 1'b0;
    txr[0] = 1'b1;
    base   = txn[0];
    @(negedge clock);
    check_eq("mrst_restart_pop", pen[0], 1'b1);
    check_eq("mrst_restart_adr", padr[0], 4'd0);
    wait_tx(0, base + 5, "mask_count");
    for (int i = 0; i < 5; i++) check_eq($sformatf("mask_byte%0d", i), txlog[0][base + i], exp6[i]);
    wait_idle(0, "mask_idle");
    repeat (5) @(negedge clock);
    check_eq("mask_ch2_pops", pop2[0] - p2base, 0);
    check_eq("mask_ch2_kept", empty_w[0][2], 1'b0);
    check_eq("mask_tail_count", txn[0], base + 5);
    check_eq("pop_nonempty_invariant", inv_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_drain_scheduler.md
Name: fifo_drain_scheduler

Overview:
Round-robin scheduler that shares one UART transmit path among NUM_CHANNELS addressed FIFOs on a common address/data bus. It selects a non-empty, enabled channel, issues a one-cycle pop via the address bus, and captures the returned byte. It then presents the byte to the transmitter on a valid/ready handshake. Within a grant it drains up to BURST_LENGTH bytes from one channel before rotating to the next.

Parameters:
NUM_CHANNELS, 4, number of FIFO channels scheduled (2..16)
ADRESS_WIDTH, 4, width of the FIFO address bus
DATA_WIDTH, 8, byte width of the FIFO data bus and the tx data
BASE_ADRESS, 0, channel i responds to address BASE_ADRESS+i
BURST_LENGTH, 1, maximum consecutive bytes per grant (>=1)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
channel_enable  input  NUM_CHANNELS  per-channel mask; 0 = channel skipped by arbitration
fifo_empty  input  NUM_CHANNELS  empty flag of each channel FIFO
fifo_data  input  DATA_WIDTH  shared FIFO data_out bus (registered by the FIFO, 0 when idle)
pop_adress  output  ADRESS_WIDTH  address of the granted channel (registered)
pop_enable  output  1  pop strobe to the addressed FIFO (registered, one cycle per byte)
tx_data  output  DATA_WIDTH  byte offered to the transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts tx_data when high together with tx_valid
busy  output  1  high in every state other than IDLE
grant  output  clog2(NUM_CHANNELS)  index of the current or last granted channel

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). All state changes occur on rising clock edges only.
- Reset (any state, any cycle): state=IDLE, pop_enable=0, pop_adress=0, tx_valid=0, tx_data=0, busy=0, grant=0, rr_pointer=0, burst_count=0. A byte in flight or captured is discarded. The FIFOs are reset separately.
- Eligible channel i: channel_enable[i]=1 and fifo_empty[i]=0.
- IDLE: if any channel is eligible, pick the first eligible index searching upward from rr_pointer with wrap (rr_pointer, rr_pointer+1, ..., NUM_CHANNELS-1, 0, ...). Register grant=pick, pop_adress=BASE_ADRESS+pick, burst_count=0, and go to POP. Otherwise stay in IDLE.
- POP (exactly 1 cycle): pop_enable=1; next state CAPTURE. pop_enable is 0 in every other state.
- CAPTURE (1 cycle): the FIFO data_out now holds the popped byte. Register tx_data=fifo_data and tx_valid=1; next state SEND.
- SEND: hold tx_valid=1 with tx_data stable until tx_ready=1 is sampled. On that edge, tx_valid=0 and burst_count+1.
  - If burst_count+1 < BURST_LENGTH and channel_enable[grant]=1 and fifo_empty[grant]=0 (sampled in this cycle), go to POP on the same channel.
  - Otherwise set rr_pointer=(grant+1) mod NUM_CHANNELS and go to IDLE.
- Latency: eligible channel seen in IDLE at cycle 0 → pop_enable high in cycle 1 → tx_valid high in cycle 3. If tx_ready is held at 1, the byte transfers at the end of cycle 3.
- Burst throughput: 3 cycles per byte (POP, CAPTURE, SEND). A new grant costs 4 cycles per byte, including IDLE.
- tx_ready while tx_valid=0 is ignored. tx_valid never drops without a transfer, except on reset.
- Masking: clearing channel_enable for the granted channel mid-burst does not abort the byte in flight. That channel is still served until the byte transfers, then the burst ends.
- Invariant: the granted channel cannot become empty between IDLE and POP, because only this block pops. The bench asserts fifo_empty[grant]=0 whenever pop_enable=1.
- Arithmetic: burst_count is wide enough for BURST_LENGTH. rr_pointer and grant wrap modulo NUM_CHANNELS. pop_adress is truncated to ADRESS_WIDTH.

Test Plan:
1. Reset: assert reset for 2 cycles with FIFOs non-empty and tx_ready=1 → pop_enable, tx_valid, busy, grant, pop_adress all 0; state IDLE. Deassert reset → first pop is issued to channel 0.
2. Single byte: channel 2 holds 0xA5, others empty, tx_ready=1 → pop_enable=1 for exactly one cycle with pop_adress=BASE_ADRESS+2. Then tx_valid=1 with tx_data=0xA5 two cycles later; back to IDLE; busy=0.
3. Round-robin, BURST_LENGTH=1: channels 0, 1, 3 each hold 2 bytes (0x10/0x11, 0x20/0x21, 0x30/0x31) → tx sequence 0x10, 0x20, 0x30, 0x11, 0x21, 0x31.
4. Burst, BURST_LENGTH=4: channel 0 holds 6 bytes (0x01..0x06), channel 1 holds 0x81, 0x82 → tx sequence 0x01..0x04, 0x81, 0x82, 0x05, 0x06.
5. Backpressure: byte 0x5A offered, tx_ready=0 for 10 cycles → tx_valid stays 1, tx_data stays 0x5A, no pop_enable. Raise tx_ready → single transfer, then tx_valid=0.
6. Mask and mid-operation reset: channel_enable=4'b1011 with all channels non-empty → channel 2 is never popped. Assert reset during SEND → tx_valid=0 next cycle, the byte is dropped, and arbitration restarts from channel 0.
